// File: rtl/euler_pkg.sv
// Shared definitions for the Euler result formatter: ASCII codes, FSM states, sizing helpers.
// The EULER_FMT_PREFIX_EN macro adds the StPrefix state.
package euler_pkg;

  localparam logic [7:0] AsciiZero  = 8'h30;
  localparam logic [7:0] AsciiCr    = 8'h0D;
  localparam logic [7:0] AsciiLf    = 8'h0A;
  localparam logic [7:0] AsciiE     = 8'h45;
  localparam logic [7:0] AsciiR     = 8'h52;
  localparam logic [7:0] AsciiP     = 8'h50;
  localparam logic [7:0] AsciiColon = 8'h3A;
  localparam logic [7:0] AsciiSpace = 8'h20;

  localparam int unsigned PrefixLen = 7;

  typedef enum logic [2:0] {
    StIdle,
    StConv,
    StEmitDig,
    StEmitCr,
    StEmitLf,
    StHold
`ifdef EULER_FMT_PREFIX_EN
    ,
    StPrefix
`endif
  } fmt_state_e;

  // Decimal digits of 2^width-1: floor(width*log10(2)) + 1.
  function automatic int unsigned calc_digits(int unsigned width);
    return (width * 30103) / 100000 + 1;
  endfunction

  // Byte idx of the "Pnnnn: " prefix for problem number num.
  function automatic logic [7:0] prefix_byte(int unsigned num, int unsigned idx);
    case (idx)
      0:       return AsciiP;
      1:       return AsciiZero + 8'((num / 1000) % 10);
      2:       return AsciiZero + 8'((num / 100) % 10);
      3:       return AsciiZero + 8'((num / 10) % 10);
      4:       return AsciiZero + 8'(num % 10);
      5:       return AsciiColon;
      default: return AsciiSpace;
    endcase
  endfunction

endpackage

// File: rtl/euler_result_uart_fmt_if.sv
// Solver-result input and ASCII byte-stream output of the result formatter.
interface euler_result_uart_fmt_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] result_in;
  logic             done_in;
  logic             error_in;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             reported;

  modport master (
    input  result_in, done_in, error_in, out_ready,
    output out_data, out_valid, busy, reported
  );

  modport slave (
    output result_in, done_in, error_in, out_ready,
    input  out_data, out_valid, busy, reported
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: WIDTH cycles after start, done_o pulses on the final shift cycle.
module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]    sh_q, sh_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, adj;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                busy_q, busy_d;

  always_comb begin
    adj = bcd_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    sh_d   = sh_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      sh_d   = bin_i;
      bcd_d  = '0;
      cnt_d  = CntW'(WIDTH);
      busy_d = 1'b1;
    end else if (busy_q) begin
      bcd_d = {adj[4*DIGITS-2:0], sh_q[WIDTH-1]};
      sh_d  = {sh_q[WIDTH-2:0], 1'b0};
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == CntW'(1));
  assign bcd_o  = bcd_q;
endmodule

// File: rtl/euler_result_uart_fmt.sv
// Formats a solver result as decimal ASCII + CR LF on a valid/ready byte stream, once per run.
// Define EULER_FMT_PREFIX_EN to prepend "Pnnnn: " (streamed while the conversion runs).
module euler_result_uart_fmt
  import euler_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DIGITS      = calc_digits(WIDTH),
  parameter int unsigned PROBLEM_NUM = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  euler_result_uart_fmt_if.master   fmt_io
);
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CntW = (IdxW > 3) ? IdxW : 3;

  fmt_state_e          state_q, state_d;
  logic                err_q, err_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                conv_start, conv_busy, conv_done;
  logic [4*DIGITS-1:0] bcd;
  logic [IdxW-1:0]     lead, cur;
  logic [3:0]          nib;

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (conv_start),
    .bin_i   (fmt_io.result_in),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (bcd)
  );

  // Highest nonzero nibble; all-zero result leaves lead at 0 so a single '0' is sent.
  always_comb begin
    lead = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) lead = IdxW'(i);
    end
  end

  // cnt_q counts bytes already sent in the current field.
  assign cur = lead - cnt_q[IdxW-1:0];
  assign nib = bcd[4*cur +: 4];

  always_comb begin
    state_d          = state_q;
    err_d            = err_q;
    cnt_d            = cnt_q;
    conv_start       = 1'b0;
    fmt_io.out_valid = 1'b0;
    fmt_io.out_data  = 8'h00;
    unique case (state_q)
      StIdle: begin
        if (fmt_io.done_in) begin
          err_d      = fmt_io.error_in;
          cnt_d      = '0;
          conv_start = !fmt_io.error_in;
`ifdef EULER_FMT_PREFIX_EN
          state_d    = StPrefix;
`else
          state_d    = fmt_io.error_in ? StEmitDig : StConv;
`endif
        end
      end
`ifdef EULER_FMT_PREFIX_EN
      StPrefix: begin
        fmt_io.out_valid = 1'b1;
        fmt_io.out_data  = prefix_byte(PROBLEM_NUM, int'(cnt_q));
        if (fmt_io.out_ready) begin
          if (cnt_q == CntW'(PrefixLen - 1)) begin
            cnt_d   = '0;
            state_d = (err_q || !conv_busy || conv_done) ? StEmitDig : StConv;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
`endif
      StConv: begin
        if (conv_done || !conv_busy) state_d = StEmitDig;
      end
      StEmitDig: begin
        fmt_io.out_valid = 1'b1;
        if (err_q) fmt_io.out_data = (cnt_q == '0) ? AsciiE : AsciiR;
        else       fmt_io.out_data = AsciiZero + {4'h0, nib};
        if (fmt_io.out_ready) begin
          if (err_q ? (cnt_q == CntW'(2)) : (cur == '0)) begin
            cnt_d   = '0;
            state_d = StEmitCr;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StEmitCr: begin
        fmt_io.out_valid = 1'b1;
        fmt_io.out_data  = AsciiCr;
        if (fmt_io.out_ready) state_d = StEmitLf;
      end
      StEmitLf: begin
        fmt_io.out_valid = 1'b1;
        fmt_io.out_data  = AsciiLf;
        if (fmt_io.out_ready) state_d = StHold;
      end
      StHold: begin
        if (!fmt_io.done_in) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fmt_io.busy     = (state_q != StIdle) && (state_q != StHold);
  assign fmt_io.reported = (state_q == StHold);
endmodule
